// File: rtl/alu_muldiv_seq_if.sv
// Bus between the pipeline / external ALU and the multi-cycle MULTU/DIVU sequencer.
// The sequencer side uses the slave modport; the pipeline/ALU side uses master.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    // Request side (from the EX stage)
    logic             start;
    logic             op;        // 0 = MULTU, 1 = DIVU
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // Status and results (to the pipeline)
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;

    // Time-shared external ALU
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;   // 00 add, 01 sub, 10 nor, 11 slt
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;

    modport slave (
        input  start, op, op_a, op_b, alu_out, alu_cout,
        output busy, done, hi, lo, dbz, alu_a, alu_b, alu_sel
    );

    modport master (
        output start, op, op_a, op_b, alu_out, alu_cout,
        input  busy, done, hi, lo, dbz, alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 32x32 unsigned multiply (shift-add) and divide (restoring)
// sequencer. It borrows the EX-stage ALU for one add/sub per cycle and keeps
// the running product / remainder:quotient in the HI/LO registers.
module alu_muldiv_seq #(
    parameter int WIDTH  = 32,
    parameter bit DBZ_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    alu_muldiv_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic             op_q;       // captured operation: 0 = MULTU, 1 = DIVU
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;     // multiplicand (MULTU) or divisor (DIVU)
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] alu_a_w;
    logic [WIDTH-1:0] alu_b_w;
    logic [1:0]       alu_sel_w;
    logic [WIDTH-1:0] div_shift;  // partial remainder shifted left by one (low 32 bits)
    logic             div_take;   // divisor fits: subtract and set quotient bit

    // Divider view of the shifted remainder; bit 32 of it lives in hi_q[31].
    always_comb begin
        div_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        div_take  = hi_q[WIDTH-1] | bus.alu_cout;
    end

    // ALU operand steering: only RUN uses the ALU, otherwise drive zeros.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block leaves a latch.
        alu_a_w   = '0;
        alu_b_w   = '0;
        alu_sel_w = SEL_ADD;
        if (state == RUN) begin
            if (op_q) begin
                alu_a_w   = div_shift;
                alu_b_w   = opnd_q;
                alu_sel_w = SEL_SUB;
            end else begin
                alu_a_w   = hi_q;
                alu_b_w   = opnd_q;
                alu_sel_w = SEL_ADD;
            end
        end
    end

    assign bus.alu_a   = alu_a_w;
    assign bus.alu_b   = alu_b_w;
    assign bus.alu_sel = alu_sel_w;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.dbz  = dbz_q;

    // Control FSM plus HI/LO datapath; all status outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        hi_q   <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                        if (bus.op) begin
                            lo_q   <= bus.op_a;
                            opnd_q <= bus.op_b;
                        end else begin
                            lo_q   <= bus.op_b;
                            opnd_q <= bus.op_a;
                        end
                        // Divide by zero needs no special datapath; only the flag is raised.
                        dbz_q <= DBZ_EN && bus.op && (bus.op_b == '0);
                    end
                end

                RUN: begin
                    if (op_q) begin
                        // Restoring divide: subtract when the divisor fits the 33-bit remainder.
                        if (div_take) begin
                            hi_q <= bus.alu_out;
                            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_q <= div_shift;
                            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add multiply: the adder carry becomes the new hi[31].
                        if (lo_q[0]) begin
                            {hi_q, lo_q} <= {bus.alu_cout, bus.alu_out, lo_q[WIDTH-1:1]};
                        end else begin
                            {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
                        end
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end

                DONE: begin
                    // start is ignored here; the pipeline must re-issue from IDLE.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that computes 32x32 unsigned multiply (MULTU) and unsigned divide (DIVU).
- It time-shares one external ALU instance: it drives the ALU A, B and sel inputs and consumes its out and Cout.
- Products and quotient/remainder are held in HI/LO registers.
- Sits beside the EX stage. The pipeline stalls on busy and reads hi/lo after done.

Parameters:
WIDTH, 32, operand/ALU width; must equal the ALU width (only 32 supported).
DBZ_EN, 1, 1 = drive dbz flag on divide-by-zero; 0 = dbz tied low.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = MULTU, 1 = DIVU; captured with start
op_a  input  32  multiplicand / dividend; captured with start
op_b  input  32  multiplier / divisor; captured with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid
hi  output  32  MULTU: product[63:32]; DIVU: remainder
lo  output  32  MULTU: product[31:0]; DIVU: quotient
dbz  output  1  DIVU with op_b == 0; valid with done, held until next start
alu_a  output  32  to ALU A
alu_b  output  32  to ALU B
alu_sel  output  2  to ALU sel: 00 add, 01 sub, 10 nor, 11 slt
alu_out  input  32  from ALU out
alu_cout  input  1  from ALU Cout (sub: 1 means A >= B unsigned)

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high.
- On reset, from any state including mid-operation:
  - state = IDLE, hi = lo = 0, busy = 0, done = 0, dbz = 0.
  - Internal divisor/multiplicand register = 0, iteration counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: latch op and op_b into internal registers.
  - MULTU: hi <= 0, lo <= op_b, multiplicand reg <= op_a.
  - DIVU: hi <= 0, lo <= op_a, divisor reg <= op_b.
  - Clear dbz, counter <= 0, go to RUN.
  - start = 0: hold; hi/lo keep the previous results.
- RUN: exactly 32 iterations, one per clock. The counter increments each edge. The edge at which counter == 31 moves the state to DONE.
- MULTU iteration:
  - alu_a = hi, alu_b = multiplicand, alu_sel = 00.
  - If lo[0] = 1: {hi, lo} <= {alu_cout, alu_out, lo[31:1]}.
  - Else: {hi, lo} <= {1'b0, hi, lo[31:1]}.
- DIVU iteration (restoring):
  - alu_a = {hi[30:0], lo[31]}, alu_b = divisor, alu_sel = 01.
  - If hi[31] = 1 or alu_cout = 1: hi <= alu_out, lo <= {lo[30:0], 1}.
  - Else: hi <= alu_a, lo <= {lo[30:0], 0}.
  - The hi[31] term covers the 33-bit shifted remainder.
- DIVU by zero:
  - Needs no special datapath; the natural result is lo = 0xFFFFFFFF, hi = dividend.
  - dbz <= 1 on the IDLE->RUN edge when op = 1, op_b == 0 and DBZ_EN = 1.
- DONE: done = 1 for exactly one cycle, busy = 1, then return to IDLE. start asserted in DONE is ignored.
- ALU port values outside RUN: alu_a = 0, alu_b = 0, alu_sel = 00.
- ALU port timing: alu_* are combinational from state and registers. alu_out/alu_cout are sampled at the same edge; the ALU is purely combinational.
- Latency: start sampled at edge k -> busy from k; done high in the cycle after edge k+32; IDLE after edge k+33. Throughput: one operation per 34 cycles minimum.
- start while busy: ignored; no queueing and no corruption of the operation in flight.
- Operand stability: op_a/op_b may change after the capture edge without effect.
- hi, lo and dbz are registered outputs and hold their values until the next accepted start.

Test Plan:
1. MULTU op_a = 0x00000DEF, op_b = 0x00000ABC -> done 33 cycles after start edge; hi = 0x00000000, lo = 0x00959184; alu_sel = 00 throughout RUN.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 (exercises alu_cout shifted into hi[31]).
3. DIVU 0x00001234 / 0x00000105 -> lo = 0x00000011, hi = 0x000000DF, dbz = 0. Also DIVU 0xFFFFFFFF / 0x80000001 -> lo = 0x00000001, hi = 0x7FFFFFFE (hi[31] path).
4. DIVU 0x12345678 / 0x00000000 -> lo = 0xFFFFFFFF, hi = 0x12345678, dbz = 1. Next MULTU 2 x 3 -> dbz = 0, lo = 0x00000006.
5. MULTU 5 x 7 started; start pulsed with DIVU 9 / 3 at RUN cycles 3 and 32 (DONE) -> result lo = 0x00000023 only; exactly one done pulse; busy falls after DONE.
6. Reset asserted asynchronously mid-clock at RUN iteration 10 -> busy, done, hi, lo, dbz = 0 immediately, no done pulse. After release, DIVU 100 / 7 -> lo = 0x0000000E, hi = 0x00000002.
